// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time and presents each returned word to decode with its address.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_jump_en_in,
    input  logic [31:0] if_jump_addr_in,
    input  logic        if_stall_in,
    output logic        if_mem_req_out,
    output logic [31:0] if_mem_addr_out,
    input  logic        if_mem_ready_in,
    input  logic        if_mem_rvalid_in,
    input  logic [31:0] if_mem_rdata_in,
    output logic [31:0] if_instr_addr_out,
    output logic [31:0] if_instr_out,
    output logic        if_instr_valid_out
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_req_q, pc_req_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic        discard_q, discard_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] jump_addr;

    assign jump_addr          = {if_jump_addr_in[31:2], 2'b00};
    assign if_mem_req_out     = (state_q == S_REQ);
    assign if_mem_addr_out    = pc_req_q;
    assign if_instr_addr_out  = addr_q;
    assign if_instr_out       = instr_q;
    assign if_instr_valid_out = valid_q;

    always_comb begin
        state_d   = state_q;
        pc_req_d  = pc_req_q;
        pc_next_d = pc_next_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        case (state_q)
            S_REQ: begin
                // The outstanding address never moves; a redirect is parked.
                if (if_mem_ready_in) state_d = S_WAIT;
                if (if_jump_en_in) begin
                    pc_next_d = jump_addr;
                    discard_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (if_mem_rvalid_in) begin
                    if (discard_q || if_jump_en_in) begin
                        discard_d = 1'b0;
                        pc_req_d  = if_jump_en_in ? jump_addr : pc_next_q;
                        state_d   = S_REQ;
                    end else begin
                        instr_d   = if_mem_rdata_in;
                        addr_d    = pc_req_q;
                        valid_d   = 1'b1;
                        pc_next_d = pc_req_q + 32'd4;
                        state_d   = S_OUT;
                    end
                end else if (if_jump_en_in) begin
                    pc_next_d = jump_addr;
                    discard_d = 1'b1;
                end
            end
            S_OUT: begin
                if (if_jump_en_in || !if_stall_in) begin
                    valid_d  = 1'b0;
                    instr_d  = NOP_INSTR;
                    pc_req_d = if_jump_en_in ? jump_addr : pc_next_q;
                    state_d  = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_req_q  <= RESET_PC;
            pc_next_q <= RESET_PC;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            addr_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_req_q  <= pc_req_d;
            pc_next_q <= pc_next_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage. Owns the PC and issues single-outstanding requests to instruction memory.
- Presents each returned instruction, with its address and a valid flag, to the decode stage.
- Accepts branch/jump redirects from execute and discards any in-flight wrong-path fetch.
- Sits between the imem port and the decode stage's instruction inputs.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven while output invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_jump_en_in  in  1  redirect request from execute, single-cycle pulse
- if_jump_addr_in  in  32  redirect target
- if_stall_in  in  1  decode not accepting; hold output
- if_mem_req_out  out  1  fetch request valid
- if_mem_addr_out  out  32  fetch address, word aligned
- if_mem_ready_in  in  1  memory accepts request this cycle
- if_mem_rvalid_in  in  1  read data valid
- if_mem_rdata_in  in  32  instruction word
- if_instr_addr_out  out  32  address of presented instruction
- if_instr_out  out  32  presented instruction word
- if_instr_valid_out  out  1  presented instruction valid

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst), and has priority over every other input.
- Reset values:
  - state=S_REQ, pc_req=RESET_PC, pc_next=RESET_PC, discard=0
  - if_instr_valid_out=0, if_instr_out=NOP_INSTR, if_instr_addr_out=0
- Combinational outputs: if_mem_req_out = (state==S_REQ); if_mem_addr_out = pc_req. Both are 0/RESET_PC-consistent in the reset cycle.
- Request rule: pc_req stays stable while if_mem_req_out=1 until the if_mem_ready_in handshake; a jump never alters the outstanding address.
- S_REQ:
  - ready=1 -> S_WAIT.
  - Jump this cycle, with or without ready: pc_next<=jump_addr, discard<=1.
- S_WAIT, rvalid=0:
  - Jump: pc_next<=jump_addr, discard<=1; stay.
- S_WAIT, rvalid=1, discard=1 or jump this cycle:
  - Drop the data; if_instr_valid_out stays 0.
  - discard<=0; pc_req<=(jump ? jump_addr : pc_next); -> S_REQ.
- S_WAIT, rvalid=1 otherwise:
  - if_instr_out<=rdata, if_instr_addr_out<=pc_req, if_instr_valid_out<=1.
  - pc_next<=pc_req+4; -> S_OUT.
- S_OUT:
  - Jump: if_instr_valid_out<=0, if_instr_out<=NOP_INSTR, pc_req<=jump_addr; -> S_REQ. Jump beats stall.
  - Else if_stall_in=0: instruction consumed. if_instr_valid_out<=0, if_instr_out<=NOP_INSTR, pc_req<=pc_next; -> S_REQ.
  - Else (stall): hold all outputs and state.
- Each instruction is valid for exactly 1 cycle when unstalled, and held for N+1 cycles under N stall cycles.
- Latency:
  - Zero-wait memory (ready in S_REQ, rvalid next cycle): valid 2 cycles after the request cycle.
  - Steady-state throughput: 1 instr / 3 cycles.
  - After reset release: req high at cycle 0.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). jump_addr[1:0] are forced to 0.
- Ignored inputs:
  - if_mem_rvalid_in outside S_WAIT.
  - if_mem_ready_in outside S_REQ.
  - if_stall_in outside S_OUT.
- Only one request is ever outstanding. At most one pending redirect is kept; the latest jump wins.
- rst mid-transaction: the state machine returns to S_REQ at RESET_PC. A late rvalid for the killed request arrives in S_REQ and is therefore ignored. Memory must not return a stale response after re-acceptance.

Test Plan:
- Reset, then zero-wait memory returning 0x00500093 at 0x0, 0x00A00113 at 0x4 -> req addr 0x0 cycle 0. valid=1 addr 0x0 instr 0x00500093 at cycle 2; next req addr 0x4 cycle 3.
- Memory ready delayed 3 cycles, rvalid delayed 2 more -> addr held 0x0 during wait, single valid pulse, no duplicate request.
- Stall 4 cycles while valid -> outputs held 5 cycles. No new req until stall drops. Next addr PC+4.
- Jump to 0x100 during S_WAIT -> returned word dropped, valid never asserted for it, next req addr 0x100.
- Jump to 0x200 in S_OUT with stall=1 -> valid drops next cycle, instr=0x00000013, req addr 0x200.
- pc_req=0xFFFFFFFC fetched and consumed -> next req addr 0x00000000. rst asserted in S_WAIT -> next cycle req addr RESET_PC, valid 0.
